fixed_integer_vector_packer: RTL and testbench

Serial-to-parallel repacker on the output side of the fixed-point matrix-dot-vector stage. It collects the one-element-per-cycle result stream (`c` / `out_valid`) into complete vectors of LENGTH elements. It re-emits each vector as LENGTH/MULTS beats of MULTS lanes, which is the `vector_b` / `in_valid` form the next layer's dot-product stage consumes. Two vector buffers (ping-pong) let the next vector be collected while the previous one is emitted.

---
 rtl/fixed_integer_vector_packer.sv | 132 +++++++++++++
 tb/tb_fixed_integer_vector_packer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_integer_vector_packer.sv
// Serial-to-parallel repacker: gathers LENGTH serial elements into a vector, then replays it
// as LENGTH/MULTS beats of MULTS lanes. Two ping-pong banks let one vector fill while the other drains.
module fixed_integer_vector_packer #(
  parameter int unsigned BITS   = 16,
  parameter int unsigned LENGTH = 10,
  parameter int unsigned MULTS  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [BITS-1:0] in_data,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [BITS-1:0] out_data [MULTS],
  output logic            busy,
  output logic            overflow
);

  localparam int unsigned Beats = LENGTH / MULTS;
  localparam int unsigned IdxW  = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(LENGTH - 1);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);

  if ((LENGTH % MULTS) != 0) begin : g_bad_mults
    $error("LENGTH must be a multiple of MULTS");
  end

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e           state_q, state_d;
  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IdxW-1:0]  wr_idx_q, wr_idx_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic             overflow_q, overflow_d;
  logic [BITS-1:0]  bank_q [2][LENGTH];

  logic emit, last_hs, wr_free, wr_en, wr_done, rd_other;

  function automatic logic [IdxW-1:0] lane_idx(input logic [BeatW-1:0] b, input int unsigned m);
    return IdxW'(32'(b) * MULTS + m);
  endfunction

  // Write side: a bank being released by the last-beat handshake may be refilled on the same edge.
  always_comb begin
    emit       = (state_q == StEmit);
    last_hs    = emit && out_ready && (beat_q == LastBeat);
    wr_free    = !full_q[wr_bank_q] || (last_hs && (rd_bank_q == wr_bank_q));
    wr_en      = in_valid && wr_free;
    wr_done    = wr_en && (wr_idx_q == LastIdx);
    wr_bank_d  = wr_bank_q;
    wr_idx_d   = wr_idx_q;
    overflow_d = overflow_q | (in_valid & ~wr_free);
    if (wr_en) begin
      if (wr_done) begin
        wr_bank_d = ~wr_bank_q;
        wr_idx_d  = '0;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end
  end

  // Read FSM; full_d already includes a vector completing on this edge (bypass into EMIT).
  always_comb begin
    full_d    = full_q;
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    beat_d    = beat_q;
    rd_other  = ~rd_bank_q;
    if (last_hs) full_d[rd_bank_q] = 1'b0;
    if (wr_done) full_d[wr_bank_q] = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (full_d[rd_bank_q]) begin
          state_d = StEmit;
          beat_d  = '0;
        end
      end
      StEmit: begin
        if (out_ready) begin
          if (beat_q == LastBeat) begin
            rd_bank_d = rd_other;
            beat_d    = '0;
            if (!full_d[rd_other]) state_d = StIdle;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_valid = emit;
    for (int unsigned m = 0; m < MULTS; m++) begin
      out_data[m] = '0;
      if (emit) out_data[m] = bank_q[rd_bank_q][lane_idx(beat_q, m)];
    end
    busy     = (|full_q) | (wr_idx_q != '0);
    overflow = overflow_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
      beat_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_idx_q   <= wr_idx_d;
      beat_q     <= beat_d;
      overflow_q <= overflow_d;
    end
  end

  // Bank storage carries no reset; stale contents are never exposed because full gates the reads.
  always_ff @(posedge clk) begin
    if (wr_en) bank_q[wr_bank_q][wr_idx_q] <= in_data;
  end

endmodule

// File: tb/tb_fixed_integer_vector_packer.sv
// Bench for fixed_integer_vector_packer: a directed table, hand sequences and random traffic,
// all checked against a queue-based model of vectors waiting to be emitted.
module tb_fixed_integer_vector_packer;

  localparam int BITS   = 16;
  localparam int LENGTH = 10;
  localparam int MULTS  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [BITS-1:0] in_data;
  logic            out_ready;
  logic            out_valid;
  logic [BITS-1:0] out_data [MULTS];
  logic            busy;
  logic            overflow;

  always #5 clk = ~clk;

  fixed_integer_vector_packer #(
    .BITS   (BITS),
    .LENGTH (LENGTH),
    .MULTS  (MULTS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .overflow  (overflow)
  );

  int checks = 0;
  int errors = 0;

  // Model: pend_q holds the not-yet-emitted elements of complete vectors, head first.
  logic [BITS-1:0] pend_q [$];
  logic [BITS-1:0] part_q [$];
  logic            ovf_m;

  typedef struct packed {
    logic            iv;
    logic [BITS-1:0] id;
    logic            rdy;
    logic            ev;
    logic [BITS-1:0] e0;
    logic [BITS-1:0] e1;
    logic            eb;
    logic            eo;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    logic ev;
    ev = (pend_q.size() != 0);
    chk("out_valid", 32'(out_valid), 32'(ev));
    for (int m = 0; m < MULTS; m++)
      chk($sformatf("out_data%0d", m), 32'(out_data[m]), ev ? 32'(pend_q[m]) : 32'd0);
    chk("busy", 32'(busy), 32'((pend_q.size() != 0) || (part_q.size() != 0)));
    chk("overflow", 32'(overflow), 32'(ovf_m));
  endtask

  task automatic model_edge(input logic iv, input logic [BITS-1:0] id, input logic rdy);
    int   sz, held, head_rem;
    logic hs, last, acc;
    sz       = pend_q.size();
    held     = (sz + LENGTH - 1) / LENGTH;
    head_rem = (sz == 0) ? 0 : ((sz - 1) % LENGTH) + 1;
    hs       = (sz != 0) && rdy;
    last     = hs && (head_rem == MULTS);
    acc      = iv && ((held - (last ? 1 : 0)) < 2);
    if (hs) repeat (MULTS) void'(pend_q.pop_front());
    if (acc) begin
      part_q.push_back(id);
      if (part_q.size() == LENGTH) begin
        foreach (part_q[k]) pend_q.push_back(part_q[k]);
        part_q.delete();
      end
    end else if (iv) begin
      ovf_m = 1'b1;
    end
  endtask

  task automatic step(input logic iv, input logic [BITS-1:0] id, input logic rdy);
    in_valid  = iv;
    in_data   = id;
    out_ready = rdy;
    @(negedge clk);
    check_model();
    model_edge(iv, id, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int first, input int n, input logic rdy);
    for (int v = first; v < first + n; v++) step(1'b1, BITS'(v), rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) step(1'b0, 16'hdead, rdy);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    pend_q.delete();
    part_q.delete();
    ovf_m = 1'b0;
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    ovf_m     = 1'b0;

    //            iv    id      rdy   ev    e0      e1      eb    eo
    tbl[0]  = '{1'b1, 16'd1,  1'b1, 1'b0, 16'd0,  16'd0,  1'b0, 1'b0};
    tbl[1]  = '{1'b1, 16'd2,  1'b1, 1'b0, 16'd0,  16'd0,  1'b1, 1'b0};
    tbl[2]  = '{1'b1, 16'd3,  1'b1, 1'b0, 16'd0,  16'd0,  1'b1, 1'b0};
    tbl[3]  = '{1'b1, 16'd4,  1'b1, 1'b0, 16'd0,  16'd0,  1'b1, 1'b0};
    tbl[4]  = '{1'b1, 16'd5,  1'b1, 1'b0, 16'd0,  16'd0,  1'b1, 1'b0};
    tbl[5]  = '{1'b1, 16'd6,  1'b1, 1'b0, 16'd0,  16'd0,  1'b1, 1'b0};
    tbl[6]  = '{1'b1, 16'd7,  1'b1, 1'b0, 16'd0,  16'd0,  1'b1, 1'b0};
    tbl[7]  = '{1'b1, 16'd8,  1'b1, 1'b0, 16'd0,  16'd0,  1'b1, 1'b0};
    tbl[8]  = '{1'b1, 16'd9,  1'b1, 1'b0, 16'd0,  16'd0,  1'b1, 1'b0};
    tbl[9]  = '{1'b1, 16'd10, 1'b1, 1'b0, 16'd0,  16'd0,  1'b1, 1'b0};
    tbl[10] = '{1'b0, 16'd0,  1'b1, 1'b1, 16'd1,  16'd2,  1'b1, 1'b0};
    tbl[11] = '{1'b0, 16'd0,  1'b1, 1'b1, 16'd3,  16'd4,  1'b1, 1'b0};
    tbl[12] = '{1'b0, 16'd0,  1'b1, 1'b1, 16'd5,  16'd6,  1'b1, 1'b0};
    tbl[13] = '{1'b0, 16'd0,  1'b1, 1'b1, 16'd7,  16'd8,  1'b1, 1'b0};
    tbl[14] = '{1'b0, 16'd0,  1'b1, 1'b1, 16'd9,  16'd10, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 16'd0,  1'b1, 1'b0, 16'd0,  16'd0,  1'b0, 1'b0};
    tbl[16] = '{1'b0, 16'd0,  1'b1, 1'b0, 16'd0,  16'd0,  1'b0, 1'b0};

    // Reset state.
    @(negedge clk);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_d0", 32'(out_data[0]), 32'd0);
    chk("reset_d1", 32'(out_data[1]), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed table: feed 1..10 and watch the five beats.
    for (int i = 0; i < 17; i++) begin
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].id;
      out_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_d0", i), 32'(out_data[0]), 32'(tbl[i].e0));
      chk($sformatf("tbl%0d_d1", i), 32'(out_data[1]), 32'(tbl[i].e1));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].eb));
      chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].eo));
      @(posedge clk);
      #1;
    end

    // Two back-to-back vectors.
    do_reset();
    feed(1, 20, 1'b1);
    idle(8, 1'b1);

    // Both banks full, elements 21..30 dropped, then drain.
    do_reset();
    for (int v = 1; v <= 30; v++) begin
      step(1'b1, BITS'(v), 1'b0);
      if (v == 20) chk("ovf_before_21", 32'(overflow), 32'd0);
      if (v == 21) chk("ovf_after_21", 32'(overflow), 32'd1);
    end
    idle(14, 1'b1);
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_ovf_sticky", 32'(overflow), 32'd1);

    // Back-pressure while beat {5,6} is presented.
    do_reset();
    feed(1, 10, 1'b1);
    idle(2, 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_d0", 32'(out_data[0]), 32'd5);
      chk("hold_d1", 32'(out_data[1]), 32'd6);
      step(1'b0, 16'h0, 1'b0);
    end
    idle(5, 1'b1);

    // Reset mid-fill discards the partial vector.
    do_reset();
    feed(1, 4, 1'b1);
    do_reset();
    feed(21, 10, 1'b1);
    idle(8, 1'b1);

    // Gapped input with junk data on idle cycles.
    do_reset();
    for (int v = 1; v <= 10; v++) begin
      step(1'b1, BITS'(v), 1'b1);
      step(1'b0, BITS'($urandom), 1'b1);
    end
    idle(8, 1'b1);

    // Random traffic with occasional resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) < 7, BITS'($urandom),
             (n < 1500) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) < 9));
      end
    end
    idle(20, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
